// File: rtl/complex_alu_pkg.sv
// Shared types and arithmetic helpers for the complex multiply/accumulate datapath.
// Holds the complex sample type, the accumulator FSM states and the shift/saturate helper.
package complex_alu_pkg;

  localparam int DATA_W    = 16;
  localparam int ACC_MAX_W = 48;

  localparam logic signed [ACC_MAX_W-1:0] SAT_MAX = 48'sd32767;
  localparam logic signed [ACC_MAX_W-1:0] SAT_MIN = -48'sd32768;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx16_t;

  typedef struct packed {
    logic                     sat;
    logic signed [DATA_W-1:0] val;
  } sat16_t;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Arithmetic shift (floor) followed by clamp to the signed 16-bit range.
  function automatic sat16_t sat16(input logic signed [ACC_MAX_W-1:0] acc,
                                   input logic [7:0] shift);
    logic signed [ACC_MAX_W-1:0] sh;
    sat16_t r;
    sh = acc >>> shift;
    if (sh > SAT_MAX) begin
      r.val = 16'sh7fff;
      r.sat = 1'b1;
    end else if (sh < SAT_MIN) begin
      r.val = 16'sh8000;
      r.sat = 1'b1;
    end else begin
      r.val = sh[DATA_W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/complex_dot_accumulator_if.sv
// Product-input and result-output handshake bundle of the complex dot accumulator.
// The slave side is the accumulator; the master side is its environment.
interface complex_dot_accumulator_if;
  import complex_alu_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic [1:0]               out_sat;
  logic [7:0]               term_cnt;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_sat, term_cnt
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_sat, term_cnt
  );

endinterface

// File: rtl/cplx_sat_shift.sv
// Combinational scale-and-saturate of a wide complex accumulator value to 16-bit complex.
// Reusable on any ACC_W-wide complex path.
module cplx_sat_shift
  import complex_alu_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc_re,
  input  logic signed [ACC_W-1:0] acc_im,
  output cplx16_t                 res,
  output logic [1:0]              sat
);

  sat16_t re_s;
  sat16_t im_s;

  // Shift and clamp each component independently.
  always_comb begin
    re_s   = sat16(ACC_MAX_W'(acc_re), 8'(SHIFT));
    im_s   = sat16(ACC_MAX_W'(acc_im), 8'(SHIFT));
    res.re = re_s.val;
    res.im = im_s.val;
    sat    = {re_s.sat, im_s.sat};
  end

endmodule

// File: rtl/complex_dot_accumulator.sv
// Accumulates N_TERMS complex products, then presents the scaled, saturated sum
// on a valid/ready output while back-pressuring the product stream.
module complex_dot_accumulator
  import complex_alu_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int GUARD   = 8,
  parameter int SHIFT   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  complex_dot_accumulator_if.slave    bus
);

  localparam int ACC_W = DATA_W + GUARD;

  acc_state_t               state_r, state_nx_s;
  logic signed [ACC_W-1:0]  acc_re_r, acc_re_nx_s;
  logic signed [ACC_W-1:0]  acc_im_r, acc_im_nx_s;
  logic [7:0]               term_cnt_r, term_cnt_nx_s;
  logic                     out_valid_r, out_valid_nx_s;
  cplx16_t                  out_r, out_nx_s;
  logic [1:0]               out_sat_r, out_sat_nx_s;
  logic signed [ACC_W-1:0]  sum_re_s;
  logic signed [ACC_W-1:0]  sum_im_s;
  cplx16_t                  sat_res_s;
  logic [1:0]               sat_flags_s;

  assign sum_re_s = acc_re_r + {{GUARD{bus.in_re[DATA_W-1]}}, bus.in_re};
  assign sum_im_s = acc_im_r + {{GUARD{bus.in_im[DATA_W-1]}}, bus.in_im};

  cplx_sat_shift #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .acc_re (sum_re_s),
    .acc_im (sum_im_s),
    .res    (sat_res_s),
    .sat    (sat_flags_s)
  );

  // Next-state and next-register logic; clear overrides every other event.
  always_comb begin
    state_nx_s     = state_r;
    acc_re_nx_s    = acc_re_r;
    acc_im_nx_s    = acc_im_r;
    term_cnt_nx_s  = term_cnt_r;
    out_valid_nx_s = out_valid_r;
    out_nx_s       = out_r;
    out_sat_nx_s   = out_sat_r;
    if (clear) begin
      state_nx_s     = ACCUM;
      acc_re_nx_s    = '0;
      acc_im_nx_s    = '0;
      term_cnt_nx_s  = 8'd0;
      out_valid_nx_s = 1'b0;
      out_sat_nx_s   = 2'b00;
    end else begin
      case (state_r)
        ACCUM: begin
          if (bus.in_valid) begin
            if (term_cnt_r == 8'(N_TERMS - 1)) begin
              out_nx_s       = sat_res_s;
              out_sat_nx_s   = sat_flags_s;
              out_valid_nx_s = 1'b1;
              acc_re_nx_s    = '0;
              acc_im_nx_s    = '0;
              term_cnt_nx_s  = 8'd0;
              state_nx_s     = HOLD;
            end else begin
              acc_re_nx_s   = sum_re_s;
              acc_im_nx_s   = sum_im_s;
              term_cnt_nx_s = term_cnt_r + 8'd1;
            end
          end else begin
            state_nx_s = ACCUM;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_nx_s = 1'b0;
            state_nx_s     = ACCUM;
          end else begin
            state_nx_s = HOLD;
          end
        end
        default: begin
          state_nx_s = ACCUM;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ACCUM;
      acc_re_r    <= '0;
      acc_im_r    <= '0;
      term_cnt_r  <= 8'd0;
      out_valid_r <= 1'b0;
      out_r       <= '0;
      out_sat_r   <= 2'b00;
    end else begin
      state_r     <= state_nx_s;
      acc_re_r    <= acc_re_nx_s;
      acc_im_r    <= acc_im_nx_s;
      term_cnt_r  <= term_cnt_nx_s;
      out_valid_r <= out_valid_nx_s;
      out_r       <= out_nx_s;
      out_sat_r   <= out_sat_nx_s;
    end
  end

  assign bus.in_ready  = (state_r == ACCUM);
  assign bus.out_valid = out_valid_r;
  assign bus.out_re    = out_r.re;
  assign bus.out_im    = out_r.im;
  assign bus.out_sat   = out_sat_r;
  assign bus.term_cnt  = term_cnt_r;

endmodule

// File: tb/tb_complex_dot_accumulator.sv
// Directed self-checking bench for complex_dot_accumulator; a second instance with
// SHIFT=2 runs in lockstep on the same stimulus to cover the scaling path.
module tb_complex_dot_accumulator;
  import complex_alu_pkg::*;

  logic clk;
  logic rst_n;
  logic clear;
  logic in_valid;
  logic out_ready;
  logic signed [15:0] in_re;
  logic signed [15:0] in_im;
  int tests_run;
  int tests_failed;

  complex_dot_accumulator_if bus0 ();
  complex_dot_accumulator_if bus2 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_re     = in_re;
  assign bus0.in_im     = in_im;
  assign bus0.out_ready = out_ready;
  assign bus2.in_valid  = in_valid;
  assign bus2.in_re     = in_re;
  assign bus2.in_im     = in_im;
  assign bus2.out_ready = out_ready;

  complex_dot_accumulator #(.N_TERMS(4), .GUARD(8), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus0));

  complex_dot_accumulator #(.N_TERMS(4), .GUARD(8), .SHIFT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic signed [15:0] re, input logic signed [15:0] im);
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat, bus0.term_cnt, bus0.in_ready}
        !== {1'b0, 16'sd0, 16'sd0, 2'b00, 8'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%0b re=%0d im=%0d sat=%b cnt=%0d rdy=%0b expected 0 0 0 00 0 1",
               bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat, bus0.term_cnt, bus0.in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(16'sd100, -16'sd50);
    push(16'sd200, 16'sd25);
    push(-16'sd300, 16'sd10);
    tests_run++;
    if ({bus0.out_valid, bus0.term_cnt} !== {1'b0, 8'd3}) begin
      tests_failed++;
      $display("FAIL basic_pre: got v=%0b cnt=%0d expected v=0 cnt=3", bus0.out_valid, bus0.term_cnt);
    end
    push(16'sd1000, 16'sd5);
    tests_run++;
    if ({bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat, bus0.term_cnt, bus0.in_ready}
        !== {1'b1, 16'sd1000, -16'sd10, 2'b00, 8'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_result: got v=%0b re=%0d im=%0d sat=%b cnt=%0d rdy=%0b expected 1 1000 -10 00 0 0",
               bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat, bus0.term_cnt, bus0.in_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({bus0.out_valid, bus0.in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL basic_release: got v=%0b rdy=%0b expected v=0 rdy=1", bus0.out_valid, bus0.in_ready);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(16'sd32767, -16'sd32768);
    tests_run++;
    if ({bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat} !== {1'b1, 16'sd32767, -16'sd32768, 2'b11}) begin
      tests_failed++;
      $display("FAIL sat_clamp: got v=%0b re=%0d im=%0d sat=%b expected 1 32767 -32768 11",
               bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat);
    end
    tests_run++;
    if ({bus2.out_valid, bus2.out_re, bus2.out_im, bus2.out_sat} !== {1'b1, 16'sd32767, -16'sd32768, 2'b00}) begin
      tests_failed++;
      $display("FAIL sat_shifted_edge: got v=%0b re=%0d im=%0d sat=%b expected 1 32767 -32768 00",
               bus2.out_valid, bus2.out_re, bus2.out_im, bus2.out_sat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(16'sd100, -16'sd50);
    push(16'sd200, 16'sd25);
    push(-16'sd300, 16'sd10);
    push(16'sd1000, 16'sd5);
    in_valid = 1'b1;
    in_re    = 16'sd7;
    in_im    = 16'sd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if ({bus0.out_valid, bus0.out_re, bus0.out_im, bus0.in_ready, bus0.term_cnt}
          !== {1'b1, 16'sd1000, -16'sd10, 1'b0, 8'd0}) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: got v=%0b re=%0d im=%0d rdy=%0b cnt=%0d expected 1 1000 -10 0 0",
                 i, bus0.out_valid, bus0.out_re, bus0.out_im, bus0.in_ready, bus0.term_cnt);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({bus0.out_valid, bus0.in_ready, bus0.term_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      tests_failed++;
      $display("FAIL hold_release: got v=%0b rdy=%0b cnt=%0d expected 0 1 0",
               bus0.out_valid, bus0.in_ready, bus0.term_cnt);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests_run++;
    if (bus0.term_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL pending_accept: got cnt=%0d expected 1", bus0.term_cnt);
    end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    push(16'sd500, 16'sd500);
    push(16'sd500, 16'sd500);
    clear = 1'b1;
    push(16'sd500, 16'sd500);
    clear = 1'b0;
    tests_run++;
    if ({bus0.term_cnt, bus0.out_valid} !== {8'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL clear_state: got cnt=%0d v=%0b expected 0 0", bus0.term_cnt, bus0.out_valid);
    end
    for (int i = 0; i < 4; i++) push(16'sd1, 16'sd2);
    tests_run++;
    if ({bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat} !== {1'b1, 16'sd4, 16'sd8, 2'b00}) begin
      tests_failed++;
      $display("FAIL clear_result: got v=%0b re=%0d im=%0d sat=%b expected 1 4 8 00",
               bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_shift();
    out_ready = 1'b1;
    push(16'sd100, -16'sd50);
    push(16'sd200, 16'sd25);
    push(-16'sd300, 16'sd10);
    push(16'sd1000, 16'sd5);
    tests_run++;
    if ({bus2.out_valid, bus2.out_re, bus2.out_im, bus2.out_sat} !== {1'b1, 16'sd250, -16'sd3, 2'b00}) begin
      tests_failed++;
      $display("FAIL shift2_result: got v=%0b re=%0d im=%0d sat=%b expected 1 250 -3 00",
               bus2.out_valid, bus2.out_re, bus2.out_im, bus2.out_sat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(16'sd10, 16'sd10);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat, bus0.term_cnt}
        !== {1'b0, 16'sd0, 16'sd0, 2'b00, 8'd0}) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%0b re=%0d im=%0d sat=%b cnt=%0d expected all zero",
               bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat, bus0.term_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(16'sd10, 16'sd10);
    tests_run++;
    if ({bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat} !== {1'b1, 16'sd40, 16'sd40, 2'b00}) begin
      tests_failed++;
      $display("FAIL post_reset_result: got v=%0b re=%0d im=%0d sat=%b expected 1 40 40 00",
               bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    clear        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    in_re        = 16'sd0;
    in_im        = 16'sd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_clear();
    test_shift();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/complex_dot_accumulator.md
Name: complex_dot_accumulator

Overview:
- Downstream consumer of the complex multiplier stage (Complex_VLSI).
- Accumulates N_TERMS consecutive complex products (real y, imaginary z) into a complex dot product.
- Scales the sum by an arithmetic right shift, saturates it to 16 bits and presents it on a valid/ready output.
- The multiplier stage drives in_valid/in_re/in_im; this block back-pressures it through in_ready while a result is held.

Parameters:
- N_TERMS, 4, products per dot product (1..2^GUARD).
- GUARD, 8, accumulator guard bits; accumulator width ACC_W = 16+GUARD.
- SHIFT, 0, arithmetic right shift applied to the final sum before saturation (0..GUARD).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort: discard the partial sum and any held result.
- in_valid  in  1  product valid from the multiplier stage.
- in_ready  out  1  block can accept a product this cycle.
- in_re  in  16  signed real part of the product (y).
- in_im  in  16  signed imaginary part of the product (z).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_re  out  16  signed saturated real result.
- out_im  out  16  signed saturated imaginary result.
- out_sat  out  2  {re_saturated, im_saturated} for the current result.
- term_cnt  out  8  products accepted in the current dot product.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: state=ACCUM, acc_re=acc_im=0, term_cnt=0, out_valid=0, out_re=out_im=0, out_sat=0. in_ready=1 once reset is released.
- Reset mid-operation: rst_n low at any time immediately discards the partial sum and any held output.
- Handshakes: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready. out_* are stable while out_valid=1 and out_ready=0.
- State ACCUM:
  - in_ready=1.
  - On each input transfer: acc += sign-extended input, independently for re and im; term_cnt += 1.
  - When the transfer is term number N_TERMS (term_cnt==N_TERMS-1 before the update):
    - next cycle out_* are loaded from sat16((acc+input) >>> SHIFT);
    - out_valid=1, out_sat set per component;
    - acc and term_cnt cleared;
    - state -> HOLD.
  - Latency: out_valid rises on the clock edge that accepts the last term, so it is visible the cycle after the last input.
- State HOLD:
  - in_ready=0 (combinational from state).
  - On an output transfer: out_valid=0, state -> ACCUM, so in_ready=1 the following cycle.
  - No input is absorbed in the same cycle as the output release.
- Arithmetic:
  - Accumulation is in two's complement, ACC_W bits, with no internal wrap given N_TERMS <= 2^GUARD.
  - sat16 clamps to +32767 / -32768 and sets the matching out_sat bit.
  - The shift rounds toward negative infinity (no rounding).
- clear:
  - Has priority over every other event in the same cycle.
  - Next state: ACCUM with acc=0, term_cnt=0, out_valid=0, out_sat=0.
  - Any input presented in the same cycle is dropped.
- N_TERMS=1: every accepted product produces a result (ACCUM->HOLD on every transfer).
- in_valid while in HOLD: ignored. The upstream must hold its data, per the handshake.

Decomposition:
- Shared package complex_alu_pkg holds:
  - DATA_W=16;
  - typedef cplx16_t (packed struct re, im);
  - function sat16(acc, shift) returning the value and a saturation flag;
  - state enum {ACCUM, HOLD}.
- One natural sub-module: cplx_sat_shift. It is combinational: ACC_W complex in, 16-bit complex plus 2 saturation flags out. It is instantiated once on the final-sum path and reusable by the sum (w, x) path later.

Test Plan:
- N_TERMS=4, SHIFT=0, products (100,-50),(200,25),(-300,10),(1000,5) on back-to-back cycles, out_ready=1 -> out_valid for exactly one cycle, starting the cycle after the 4th input. Result (1000,-10), out_sat=00, then in_ready=1.
- Four products (32767,-32768) -> raw sums 131068 / -131072 -> out=(32767,-32768), out_sat=11.
- Complete one dot product, then hold out_ready=0 for 5 cycles with in_valid=1 -> out stays (1000,-10), in_ready=0, term_cnt=0. On out_ready=1: out_valid drops next cycle and accumulation of the pending input starts the cycle after.
- Two products (500,500), then clear=1 together with in_valid, then four products (1,2) -> result (4,8). The cleared partials and the dropped input are absent.
- SHIFT=2, the first scenario's stimulus -> out=(250,-3).
- Async reset: assert rst_n=0 mid-cycle after 3 terms -> all outputs zero immediately, without waiting for a clock edge. After release, four (10,10) -> (40,40).
